// File: rtl/wb_reg_file.sv
// rtl/wb_reg_file.sv - MIPS write-back stage register file with retire counter (option macro: WB_REG_FILE_BYPASS_EN)
module wb_reg_file #(
  parameter int          RETIRE_W = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite,
  input  logic [4:0]          writeReg,
  input  logic [31:0]         wData,
  input  logic [31:0]         instru,
  input  logic [4:0]          readReg1,
  input  logic [4:0]          readReg2,
  output logic [31:0]         readData1,
  output logic [31:0]         readData2,
  input  logic [4:0]          dbgReg,
  output logic [31:0]         dbgData,
  output logic [RETIRE_W-1:0] retired
);

  // $0 has no storage; only indices 1..31 are real registers.
  logic [31:0]         regs_q [1:31];
  logic [RETIRE_W-1:0] retired_q;
  logic [RETIRE_W-1:0] retired_d;
  logic                wr_en;

  assign wr_en = RegWrite && (writeReg != 5'd0);

  // Retire counter next state: bubbles do not count, wraps naturally.
  always_comb begin
    retired_d = retired_q;
    if (instru != NOP_WORD) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  // Register array commit; reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (wr_en) begin
      regs_q[writeReg] <= wData;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  // Committed-state read ports; index 0 always reads zero.
  always_comb begin
    readData1 = (readReg1 == 5'd0) ? 32'h0 : regs_q[readReg1];
    readData2 = (readReg2 == 5'd0) ? 32'h0 : regs_q[readReg2];
    dbgData   = (dbgReg   == 5'd0) ? 32'h0 : regs_q[dbgReg];
`ifdef WB_REG_FILE_BYPASS_EN
    // Same-cycle forwarding of the WB result to ID; wr_en already excludes $0.
    if (wr_en && (writeReg == readReg1)) begin
      readData1 = wData;
    end
    if (wr_en && (writeReg == readReg2)) begin
      readData2 = wData;
    end
`endif
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// tb/tb_wb_reg_file.sv - directed self-checking bench for wb_reg_file
module tb_wb_reg_file;

  localparam int RW = 4;
`ifdef WB_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWrite;
  logic [4:0]    writeReg;
  logic [31:0]   wData;
  logic [31:0]   instru;
  logic [4:0]    readReg1;
  logic [4:0]    readReg2;
  logic [31:0]   readData1;
  logic [31:0]   readData2;
  logic [4:0]    dbgReg;
  logic [31:0]   dbgData;
  logic [RW-1:0] retired;

  int checks = 0;
  int errors = 0;

  wb_reg_file #(.RETIRE_W(RW), .NOP_WORD(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .writeReg  (writeReg),
    .wData     (wData),
    .instru    (instru),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .dbgReg    (dbgReg),
    .dbgData   (dbgData),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    RegWrite = 1'b1;
    writeReg = idx;
    wData    = val;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      instru = 32'h2008_0001;
      tick();
    end
    instru = 32'h0;
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      dbgReg   = 5'(i);
      #1;
      check({tag, "_rd1"}, readData1, 32'h0);
      check({tag, "_rd2"}, readData2, 32'h0);
      check({tag, "_dbg"}, dbgData, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; writeReg = 5'd0; wData = 32'h0;
    instru = 32'h0; readReg1 = 5'd0; readReg2 = 5'd0; dbgReg = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    all_zero("rst_init");
    check("rst_retired", 32'(retired), 32'd0);

    // 3 instructions, 2 bubbles, 1 instruction -> 4
    feed(3);
    tick();
    tick();
    feed(1);
    check("retire_4", 32'(retired), 32'd4);

    // writes to $0 are dropped
    readReg1 = 5'd0;
    RegWrite = 1'b1; writeReg = 5'd0; wData = 32'hDEAD_BEEF;
    #1;
    check("zero_before", readData1, 32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("zero_after", readData1, 32'h0);

    // basic write, visible next cycle on rd2 and dbg
    wr(5'd8, 32'hCAFE_F00D);
    readReg2 = 5'd8; dbgReg = 5'd8;
    #1;
    check("basic_rd2", readData2, 32'hCAFE_F00D);
    check("basic_dbg", dbgData, 32'hCAFE_F00D);

    // same-cycle read-during-write
    wr(5'd9, 32'h0000_0005);
    readReg1 = 5'd9; readReg2 = 5'd9; dbgReg = 5'd9;
    RegWrite = 1'b1; writeReg = 5'd9; wData = 32'h1111_0000;
    #1;
    check("byp_rd1", readData1, BYP ? 32'h1111_0000 : 32'h0000_0005);
    check("byp_rd2", readData2, BYP ? 32'h1111_0000 : 32'h0000_0005);
    check("byp_dbg", dbgData, 32'h0000_0005);
    readReg1 = 5'd8;
    #1;
    check("byp_other", readData1, 32'hCAFE_F00D);
    readReg1 = 5'd9;
    tick();
    RegWrite = 1'b0;
    #1;
    check("post_rd1", readData1, 32'h1111_0000);
    check("post_rd2", readData2, 32'h1111_0000);
    check("post_dbg", dbgData, 32'h1111_0000);

    // back-to-back writes to one index: last one wins
    wr(5'd4, 32'hAAAA_0001);
    wr(5'd4, 32'hBBBB_0002);
    dbgReg = 5'd4;
    #1;
    check("last_wins", dbgData, 32'hBBBB_0002);

    // preload $5, count more instructions, then reset with a colliding write
    wr(5'd5, 32'h0000_1234);
    dbgReg = 5'd5;
    #1;
    check("pre_r5", dbgData, 32'h0000_1234);
    feed(3);
    check("pre_retired", 32'(retired), 32'd7);
    reset = 1'b1; RegWrite = 1'b1; writeReg = 5'd3; wData = 32'h7;
    instru = 32'h2008_0001;
    tick();
    reset = 1'b0; RegWrite = 1'b0; instru = 32'h0;
    dbgReg = 5'd3;
    #1;
    check("rst_vs_wr", dbgData, 32'h0);
    check("rst_retired2", 32'(retired), 32'd0);
    all_zero("rst_mid");

    // wrap of the 4-bit counter
    feed(15);
    check("wrap_15", 32'(retired), 32'd15);
    feed(1);
    check("wrap_0", 32'(retired), 32'd0);
    feed(1);
    check("wrap_1", 32'(retired), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
# wb_reg_file

Write-back stage register file for the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs (`RegWrite`, `writeReg`, `wData`, `instru`) and commits results into a 32 x 32-bit general-purpose register array. It serves the ID stage's two combinational read ports and an extra debug read port. It also keeps a retired-instruction counter for simulation and performance checks.

## Interface
Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `NOP_WORD`, default 32'h0000_0000: instruction word treated as a pipeline bubble (not counted as retired).

Ports:
- `clk` input 1: pipeline clock. All state updates occur on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `RegWrite` input 1: write enable from MEM/WB.
- `writeReg` input 5: destination register index from MEM/WB.
- `wData` input 32: write-back data from MEM/WB.
- `instru` input 32: instruction word currently in WB.
- `readReg1` input 5: ID-stage rs index.
- `readReg2` input 5: ID-stage rt index.
- `readData1` output 32: value of `readReg1`.
- `readData2` output 32: value of `readReg2`.
- `dbgReg` input 5: debug read index.
- `dbgData` output 32: value of `dbgReg`. This port is never bypassed.
- `retired` output RETIRE_W: count of non-bubble instructions that have reached WB.

## Operation
- Storage is `regs[0..31]`, 32 bits each. `regs[0]` is hardwired to zero.
- Write rule: at posedge, if `!reset && RegWrite && writeReg != 0`, then `regs[writeReg] <= wData`.
- Writes to index 0 are discarded silently.
- Reads are combinational from the array. Any read of index 0 returns 0, regardless of bypass.
- Read-during-write handling depends on `WB_REG_FILE_BYPASS_EN` (see Configuration).
- Retire counter:
  - At posedge, if `!reset && instru != NOP_WORD`, then `retired <= retired + 1`.
  - It wraps modulo 2^RETIRE_W; it does not saturate.
  - The counter is independent of `RegWrite`, so stores and branches count.
- `dbgData` always reflects array contents only: the committed state as of the last edge.

## Timing
- Reset: on a posedge with `reset=1`, all 31 writable registers become 0 and `retired` becomes 0.
  - Reset has priority over a simultaneous write and over a simultaneous retire.
  - After reset, `readData1`, `readData2` and `dbgData` read 0 for every index until the first write.
- Reset asserted mid-stream discards the in-flight WB write of that cycle. There are no partial updates.
- Write latency:
  - A value presented in cycle N is visible through the array from cycle N+1.
  - With bypass enabled it is also visible on `readData1`/`readData2` within cycle N, combinationally.
- Simultaneous events:
  - Both read ports addressing the write target at once both receive bypassed data when bypass is enabled.
  - `dbgReg` equal to `writeReg` shows the old value in cycle N.
- Consecutive writes to the same index: the last edge wins. There is no buffering.
- There is no handshake; WB never stalls.
- The block is purely edge-updated plus combinational read paths, and holds no other state.

## Configuration
- Macro: `WB_REG_FILE_BYPASS_EN`.
- Defined: `readDataK = wData` when `RegWrite && writeReg != 0 && writeReg == readRegK`; otherwise `readDataK` comes from the array. This resolves the WB-to-ID hazard in the same cycle, emulating the classic write-first-half / read-second-half register file.
- Undefined: `readDataK` comes from the array only. The hazard unit must stall ID by one cycle on a WB-to-ID dependency.

## Test plan
- Reset clears state: preload via writes `$5=0x1234`, then `retired` has counted some instructions; assert `reset` for one edge -> all reads return 0 and `retired=0` on the next cycle.
- Zero register: `RegWrite=1`, `writeReg=0`, `wData=0xDEADBEEF` -> `readData1` with `readReg1=0` stays 0 before and after the edge.
- Basic write/read: write `$8=0xCAFEF00D` at cycle N -> `readData2` with `readReg2=8` and `dbgData` with `dbgReg=8` both equal `0xCAFEF00D` in cycle N+1.
- Same-cycle bypass: in cycle N, write `$9=0x11110000`, with `readReg1=readReg2=9` and `$9` previously `0x5`.
  - With macro defined: both reads equal `0x11110000` in cycle N and `dbgData=0x5`.
  - Without macro: both reads equal `0x5` in cycle N and `0x11110000` in cycle N+1.
- Reset versus write collision: `reset=1` together with `RegWrite=1`, `writeReg=3`, `wData=7` -> `$3` reads 0 afterwards.
- Retire count and wrap: feed `instru` as 3 non-zero words, 2 bubbles, then 1 non-zero word -> `retired=4`. With `RETIRE_W=4`, preload to 15 by feeding 15 instructions, then one more instruction -> `retired=0`.
